// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forward selects, memory-wait
// FSM states and the shadow pipeline-register entry.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EM = 2'b01;
    localparam logic [1:0] FWD_MW = 2'b10;

    // Shadow rd is held zero-extended to this width so the struct is AW-independent.
    localparam int RD_MAX_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mw_state_e;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                reg_write;
        logic                is_load;
    } sh_entry_t;

    localparam sh_entry_t SH_EMPTY = '0;

    // A load in ExMem has no data yet, so it never forwards from that stage.
    function automatic logic [1:0] fwd_sel(
        input sh_entry_t           em,
        input sh_entry_t           mw,
        input logic [RD_MAX_W-1:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (em.valid && em.reg_write && !em.is_load && (em.rd == src)) begin
                sel = FWD_EM;
            end else if (mw.valid && mw.reg_write && (mw.rd == src)) begin
                sel = FWD_MW;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker: stalls while a request is outstanding and raises
// a one-cycle error once TIMEOUT consecutive wait cycles have elapsed.
//
// state | meaning
// IDLE  | no wait in progress; an unacked request stalls for its first cycle
// WAIT  | request outstanding, wcnt = wait cycles already stalled
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ack,
    output logic mstall,
    output logic mem_err
);

    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WC_LAST = WCW'(TIMEOUT);

    mw_state_e      state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           pending;

    // A dropped request while waiting is treated like an ack.
    assign pending = mem_req & ~mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (pending && (TIMEOUT != 0)) begin
                    state_d = WAIT;
                    wcnt_d  = WCW'(1);
                end
            end
            WAIT: begin
                if (!pending || (wcnt_q == WC_LAST)) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        mstall  = 1'b0;
        mem_err = 1'b0;
        case (state_q)
            IDLE: mstall = pending;
            WAIT: begin
                if (pending) begin
                    if (wcnt_q == WC_LAST) begin
                        mem_err = 1'b1;
                    end else begin
                        mstall = 1'b1;
                    end
                end
            end
            default: begin
                mstall  = 1'b0;
                mem_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: forwarding, load-use
// and memory-wait stalls, branch flushes and saturating stall counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int AW      = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [AW-1:0]    ex_rs1,
    input  logic [AW-1:0]    ex_rs2,
    input  logic [AW-1:0]    ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_is_load,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             bubble_memwb,
    output logic [1:0]       fwd_rs1,
    output logic [1:0]       fwd_rs2,
    output logic             mem_err,
    output logic [CNT_W-1:0] cnt_lu_stall,
    output logic [CNT_W-1:0] cnt_mem_stall
);

    logic             mstall;
    logic             lu;
    logic             lu_win;
    sh_entry_t        ex_entry;
    sh_entry_t        sh_em_q, sh_em_d;
    sh_entry_t        sh_mw_q, sh_mw_d;
    logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
    logic [CNT_W-1:0] cnt_mem_q, cnt_mem_d;

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait (
        .clk     (clk),
        .rst     (rst),
        .mem_req (mem_req),
        .mem_ack (mem_ack),
        .mstall  (mstall),
        .mem_err (mem_err)
    );

    always_comb begin
        ex_entry           = SH_EMPTY;
        ex_entry.valid     = 1'b1;
        ex_entry.rd        = RD_MAX_W'(ex_rd);
        ex_entry.reg_write = ex_reg_write;
        ex_entry.is_load   = ex_is_load;
    end

    assign fwd_rs1 = fwd_sel(sh_em_q, sh_mw_q, RD_MAX_W'(ex_rs1));
    assign fwd_rs2 = fwd_sel(sh_em_q, sh_mw_q, RD_MAX_W'(ex_rs2));

    assign lu = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // A taken branch discards the ID instruction, so it beats the load-use stall.
    assign lu_win = !mstall && !branch_taken && lu;

    always_comb begin
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        stall_mem    = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        bubble_memwb = mstall | mem_err;
        if (mstall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (branch_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (lu) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            flush_idex = 1'b1;
        end
    end

    always_comb begin
        sh_em_d = sh_em_q;
        sh_mw_d = sh_mw_q;
        if (!stall_mem) begin
            sh_mw_d = bubble_memwb ? SH_EMPTY : sh_em_q;
            sh_em_d = stall_ex ? SH_EMPTY : ex_entry;
        end
    end

    always_comb begin
        cnt_lu_d  = cnt_lu_q;
        cnt_mem_d = cnt_mem_q;
        if (lu_win && (cnt_lu_q != '1)) begin
            cnt_lu_d = cnt_lu_q + CNT_W'(1);
        end
        if (mstall && (cnt_mem_q != '1)) begin
            cnt_mem_d = cnt_mem_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_em_q   <= SH_EMPTY;
            sh_mw_q   <= SH_EMPTY;
            cnt_lu_q  <= '0;
            cnt_mem_q <= '0;
        end else begin
            sh_em_q   <= sh_em_d;
            sh_mw_q   <= sh_mw_d;
            cnt_lu_q  <= cnt_lu_d;
            cnt_mem_q <= cnt_mem_d;
        end
    end

    assign cnt_lu_stall  = cnt_lu_q;
    assign cnt_mem_stall = cnt_mem_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int AW   = 5;
    localparam int T    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_reg_write, ex_is_load;
    logic          branch_taken, mem_req, mem_ack;
    logic          stall_if, stall_id, stall_ex, stall_mem;
    logic          flush_ifid, flush_idex, bubble_memwb, mem_err;
    logic [1:0]    fwd_rs1, fwd_rs2;
    logic [CW-1:0] cnt_lu_stall, cnt_mem_stall;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.AW(AW), .TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .bubble_memwb(bubble_memwb),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .mem_err(mem_err),
        .cnt_lu_stall(cnt_lu_stall), .cnt_mem_stall(cnt_mem_stall)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ExMem / MemWb contents as the pipeline sees them, plus a count of
    // consecutive memory-wait stall cycles.
    bit m_ok = 0;
    bit em_v, em_rw, em_ld, mw_v, mw_rw, mw_ld;
    int em_rd, mw_rd;
    int waited, c_lu, c_mem;
    bit pend, ms, er, lu, bt;
    int e_sif, e_sid, e_sex, e_smem, e_fif, e_fid, e_bub;

    function automatic int mfwd(input int src);
        if (src == 0) return 0;
        if (em_v && em_rw && !em_ld && em_rd == src) return 1;
        if (mw_v && mw_rw && mw_rd == src) return 2;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_ok = 1; em_v = 0; mw_v = 0; em_rw = 0; mw_rw = 0; em_ld = 0; mw_ld = 0;
            em_rd = 0; mw_rd = 0; waited = 0; c_lu = 0; c_mem = 0;
        end else if (m_ok) begin
            pend = mem_req && !mem_ack;
            ms   = pend && (T == 0 || waited < T);
            er   = pend && (T != 0) && (waited == T);
            bt   = branch_taken;
            lu   = ex_is_load && ex_reg_write && ex_rd != 0 &&
                   ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            e_sif = 0; e_sid = 0; e_sex = 0; e_smem = 0; e_fif = 0; e_fid = 0;
            if (ms) begin
                e_sif = 1; e_sid = 1; e_sex = 1; e_smem = 1;
            end else if (bt) begin
                e_fif = 1; e_fid = 1;
            end else if (lu) begin
                e_sif = 1; e_sid = 1; e_fid = 1;
            end
            e_bub = (ms || er) ? 1 : 0;
            chk("stall_if", stall_if, e_sif);
            chk("stall_id", stall_id, e_sid);
            chk("stall_ex", stall_ex, e_sex);
            chk("stall_mem", stall_mem, e_smem);
            chk("flush_ifid", flush_ifid, e_fif);
            chk("flush_idex", flush_idex, e_fid);
            chk("bubble_memwb", bubble_memwb, e_bub);
            chk("mem_err", mem_err, er ? 1 : 0);
            chk("fwd_rs1", fwd_rs1, mfwd(int'(ex_rs1)));
            chk("fwd_rs2", fwd_rs2, mfwd(int'(ex_rs2)));
            chk("cnt_lu_stall", cnt_lu_stall, c_lu);
            chk("cnt_mem_stall", cnt_mem_stall, c_mem);
            if (!ms) begin
                mw_v = e_bub ? 0 : em_v;
                mw_rd = em_rd; mw_rw = em_rw; mw_ld = em_ld;
                em_v = 1; em_rd = int'(ex_rd); em_rw = ex_reg_write; em_ld = ex_is_load;
            end
            if (!ms && !bt && lu && c_lu < CMAX) c_lu++;
            if (ms && c_mem < CMAX) c_mem++;
            waited = ms ? waited + 1 : 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input int rd, input bit rw, input bit ld, input int rs1, input int rs2);
        ex_rd = rd[AW-1:0]; ex_reg_write = rw; ex_is_load = ld;
        ex_rs1 = rs1[AW-1:0]; ex_rs2 = rs2[AW-1:0];
    endtask

    task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2);
        id_rs1 = rs1[AW-1:0]; id_use_rs1 = u1; id_rs2 = rs2[AW-1:0]; id_use_rs2 = u2;
    endtask

    task automatic idle();
        set_ex(0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0);
        branch_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    initial begin
        idle();
        rst = 1; tick(); tick(); rst = 0;
        #2;
        chk("rst_ctrl", {stall_if, stall_id, stall_ex, stall_mem, flush_ifid, flush_idex,
                         bubble_memwb, mem_err}, 0);
        chk("rst_fwd", {fwd_rs1, fwd_rs2}, 0);
        chk("rst_cnt", {cnt_lu_stall, cnt_mem_stall}, 0);
        tick();

        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        set_ex(5, 1, 1, 0, 0); set_id(5, 1, 1, 1);
        #2;
        chk("lu_stall_if", stall_if, 1);
        chk("lu_stall_id", stall_id, 1);
        chk("lu_flush_idex", flush_idex, 1);
        chk("lu_stall_ex", stall_ex, 0);
        tick();
        chk("lu_cnt", cnt_lu_stall, 1);
        set_ex(0, 0, 0, 0, 0);
        #2;
        chk("lu_released", stall_if, 0);
        tick();
        set_ex(6, 1, 0, 5, 1); set_id(0, 0, 0, 0);
        #2;
        chk("lu_fwd_rs1", fwd_rs1, 2);
        chk("lu_fwd_rs2", fwd_rs2, 0);
        tick();

        // two producers of x3 back to back
        set_ex(3, 1, 0, 0, 0); tick();
        set_ex(3, 1, 0, 0, 0); tick();
        set_ex(7, 1, 0, 3, 3);
        #2;
        chk("dbl_fwd_rs1", fwd_rs1, 1);
        chk("dbl_fwd_rs2", fwd_rs2, 1);
        tick();
        set_ex(0, 0, 0, 3, 0);
        #2;
        chk("dbl_mw_fwd", fwd_rs1, 2);
        tick();

        // x0 producers never forward or stall
        set_ex(0, 1, 1, 0, 0); set_id(0, 1, 0, 1);
        #2;
        chk("x0_no_lu", {stall_if, flush_idex}, 0);
        tick();
        set_ex(0, 1, 0, 0, 0); set_id(0, 0, 0, 0); tick();
        set_ex(8, 1, 0, 0, 0);
        #2;
        chk("x0_fwd", {fwd_rs1, fwd_rs2}, 0);
        tick();
        idle();

        // memory wait released by ack on the 4th cycle
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mw_stall", {stall_if, stall_id, stall_ex, stall_mem, bubble_memwb}, 5'b11111);
            tick();
        end
        mem_ack = 1;
        #2;
        chk("mw_release", {stall_if, stall_mem, bubble_memwb, mem_err}, 0);
        tick();
        chk("mw_cnt", cnt_mem_stall, 3);
        mem_ack = 0;

        // timeout with no ack
        for (int i = 0; i < T; i++) begin
            #2;
            chk("to_stall", stall_mem, 1);
            tick();
        end
        #2;
        chk("to_err", {mem_err, bubble_memwb, stall_if}, 3'b110);
        tick();
        mem_req = 0;
        #2;
        chk("to_err_pulse", mem_err, 0);
        chk("to_cnt", cnt_mem_stall, 7);
        tick();

        // reset in the middle of a wait
        mem_req = 1; tick(); tick();
        rst = 1; tick(); rst = 0; mem_req = 0;
        #2;
        chk("rw_idle", {mem_err, stall_mem}, 0);
        chk("rw_cnt", {cnt_lu_stall, cnt_mem_stall}, 0);
        tick();
        mem_req = 1;
        for (int i = 0; i < T; i++) begin
            #2;
            chk("rw_fresh_stall", stall_mem, 1);
            tick();
        end
        #2;
        chk("rw_fresh_err", mem_err, 1);
        tick();
        idle();

        // branch against load-use, then branch under a memory stall
        set_ex(5, 1, 1, 0, 0); set_id(5, 1, 0, 0); branch_taken = 1;
        #2;
        chk("br_lu_flush", {flush_ifid, flush_idex}, 2'b11);
        chk("br_lu_stall", {stall_if, stall_id}, 0);
        tick();
        chk("br_lu_cnt", cnt_lu_stall, 0);
        set_ex(0, 0, 0, 0, 0); set_id(0, 0, 0, 0); mem_req = 1;
        #2;
        chk("br_ms_flush", {flush_ifid, stall_if}, 2'b01);
        tick();
        mem_ack = 1;
        #2;
        chk("br_ms_release", {flush_ifid, stall_if}, 2'b10);
        tick();
        idle();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            set_ex($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 7), $urandom_range(0, 7));
            set_id($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
            mem_req      = ($urandom_range(0, 3) != 0);
            mem_ack      = ($urandom_range(0, 4) == 0);
            tick();
        end
        rst = 0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and pipeline-control unit for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It is a parametrised successor to the fixed-latency hazard logic. It adds:
- x0-aware forwarding;
- variable-latency data-memory wait with `mem_ack` handshake and timeout;
- branch/load-use priority resolution;
- saturating stall performance counters.

It keeps its own shadow copy of EX/MEM and MEM/WB destination state, so the datapath only supplies EX-stage information.

## Interface
- `AW`, 5, register-address width
- `TIMEOUT`, 16, max consecutive memory-wait stall cycles before bus error; 0 = never time out
- `CNT_W`, 32, width of each performance counter
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `id_rs1`, `id_rs2`  in  AW  source registers of the instruction in ID
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction actually reads that source
- `ex_rs1`, `ex_rs2`  in  AW  source registers of the instruction in EX
- `ex_rd`  in  AW  destination of the instruction in EX
- `ex_reg_write`, `ex_is_load`  in  1  EX instruction writes rd / is a load
- `branch_taken`  in  1  EX resolves a taken branch or jump
- `mem_req`  in  1  MEM-stage instruction is a load/store (`mreq`)
- `mem_ack`  in  1  data memory completes the request this cycle
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`  out  1  hold PC / IfId / IdEx / ExMem
- `flush_ifid`, `flush_idex`  out  1  load NOP into that register
- `bubble_memwb`  out  1  load NOP into MemWb
- `fwd_rs1`, `fwd_rs2`  out  2  EX operand select: 00 regfile, 01 ExMem, 10 MemWb
- `mem_err`  out  1  one-cycle pulse on memory timeout
- `cnt_lu_stall`, `cnt_mem_stall`  out  CNT_W  saturating stall-cycle counters

## Operation
**Shadow state.** The block holds shadow registers `sh_em` and `sh_mw`, each `{valid, rd, reg_write, is_load}`.
- When `stall_mem`=0:
  - `sh_mw` ← `sh_em`, or an invalid entry if `bubble_memwb`=1.
  - `sh_em` ← EX inputs, or an invalid entry if `stall_ex`.
- When `stall_mem`=1, both shadow registers hold.

**Forwarding** (combinational, per source):
- 01 if `sh_em` is valid, writes the register, is not a load, and its rd equals the source and is nonzero.
- Otherwise 10 if `sh_mw` is valid, writes the register, and its rd equals the source and is nonzero.
- Otherwise 00.
- ExMem has priority over MemWb. A source of x0 always gives 00.

**Load-use hazard** (`lu`): `ex_is_load` & `ex_reg_write` & `ex_rd`≠0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).

**Memory-wait state machine** (sub-module `mem_wait_fsm`), states IDLE and WAIT, with counter `wcnt`:
- IDLE:
  - `mem_req` & !`mem_ack` & `TIMEOUT`≠0 → WAIT, `wcnt`=1, `mstall`=1.
  - If `TIMEOUT`=0, the same condition gives `mstall`=1 and the state stays IDLE.
- WAIT:
  - `mem_ack` → IDLE with `mstall`=0; the pipeline advances in this cycle.
  - `wcnt`==`TIMEOUT` → IDLE, `mem_err`=1, `mstall`=0, `bubble_memwb`=1.
  - Otherwise `mstall`=1 and `wcnt`++.

**Output priority, highest first:**
1. `mstall`: all four stalls = 1, `flush_ifid` = `flush_idex` = 0, `bubble_memwb` = 1.
2. `branch_taken`: `flush_ifid` = `flush_idex` = 1, all stalls = 0. This overrides `lu`, because the ID instruction is discarded.
3. `lu`: `stall_if` = `stall_id` = 1, `flush_idex` = 1.
4. Otherwise all outputs are 0.

**Counters** saturate at all-ones.
- `cnt_lu_stall` +1 in each cycle where `lu` is the winning condition.
- `cnt_mem_stall` +1 in each cycle where `mstall`=1.

## Timing
- All control and forward outputs are combinational from the inputs and the registered state. Zero latency: `mem_ack` high releases the stall in the same cycle.
- State, shadows and counters update on the rising edge of `clk`.
- Values after reset (`rst`=1 on a rising edge of `clk`):
  - FSM in IDLE, `wcnt`=0.
  - Shadows invalid.
  - Counters 0.
  - `mem_err`=0.
  - With idle inputs, all outputs are 0.
- Reset mid-WAIT aborts the wait with no `mem_err`.
- A load-use hazard costs exactly 1 stall cycle; the dependent instruction then receives forward 10.
- With `TIMEOUT`=T and `mem_ack` never arriving: stall cycles 0..T-1, then `mem_err` in cycle T.
- `mem_req` low while in WAIT is treated as `mem_ack`: the state returns to IDLE with no error.

## Structure
- Package `pipe_ctrl_pkg`: FWD_RF=2'b00, FWD_EM=2'b01, FWD_MW=2'b10; FSM state enum {IDLE, WAIT}; shadow-entry struct.
- Sub-module `mem_wait_fsm`: registers state and `wcnt`; outputs `mstall` and `mem_err`.
- Top level: shadow registers, forward compare, priority logic and counters.

## Test plan
- Load-use: EX `lw x5` (`ex_rd`=5, load), ID `add x6,x5,x1` → cycle 0: `stall_if`=`stall_id`=`flush_idex`=1, `cnt_lu_stall`=1. Cycle 2: EX `ex_rs1`=5 → `fwd_rs1`=10.
- Double producer: `addi x3` then `add x3` back-to-back, consumer reads x3 in EX → `fwd_rs1`=01 (nearer producer wins). Next slot with only `sh_mw` holding x3 → 10.
- x0: producer writes x0, consumer reads x0 → `fwd_rs1`=`fwd_rs2`=00, no load-use stall even if the producer is a load.
- Memory wait: `mem_req`=1 with `mem_ack` rising on the 4th cycle → all stalls and `bubble_memwb` high for 3 cycles, released in the ack cycle, `cnt_mem_stall`=3, `mem_err`=0.
- Timeout: `TIMEOUT`=4, `mem_req`=1, `mem_ack`=0 → 4 stall cycles, then `mem_err`=1 for one cycle with `bubble_memwb`=1, back in IDLE. Assert `rst` mid-WAIT in a second run → state IDLE, no `mem_err`.
- Simultaneous events:
  - `branch_taken` & `lu` → flushes=1, stalls=0, `cnt_lu_stall` unchanged.
  - `branch_taken` during `mstall` → flushes=0 until the stall releases.
